// File: rtl/mem_byte_loader.sv
// mem_byte_loader: packs a valid/ready byte stream into 32-bit little-endian
// words and writes them to consecutive addresses of the on-chip memory.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; in_ready low, busy low
// S_ACCEPT | collecting bytes into lanes 0..3; in_ready high
// S_WRITE  | single-cycle memory write of the packed word
// S_DONE   | one-cycle done pulse, then back to idle
module mem_byte_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remain;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;

    // in_ready is the only combinational output: a pure state decode
    assign in_ready  = (state == S_ACCEPT);
    assign mem_clken = 1'b1;

    // Main FSM with registered memory strobes, status and checksum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cur_addr       <= '0;
            remain         <= '0;
            byte_idx       <= 2'd0;
            word_buf       <= 24'd0;
            mem_address    <= '0;
            mem_byteenable <= 4'hF;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            checksum       <= 8'd0;
        end else begin
            // strobes are single-cycle; they are only raised on entry to WRITE
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            done           <= 1'b0;
            mem_byteenable <= 4'hF;
            if (abort) begin
                // partial word is dropped; checksum keeps the partial sum
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            cur_addr <= start_addr;
                            remain   <= word_count;
                            checksum <= 8'd0;
                            byte_idx <= 2'd0;
                            busy     <= 1'b1;
                            if (word_count == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_ACCEPT;
                            end
                        end
                    end
                    S_ACCEPT: begin
                        if (in_valid) begin
                            checksum <= checksum + in_data;
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0: word_buf[7:0]   <= in_data;
                                2'd1: word_buf[15:8]  <= in_data;
                                2'd2: word_buf[23:16] <= in_data;
                                default: begin
                                    mem_writedata  <= {in_data, word_buf};
                                    mem_address    <= cur_addr;
                                    mem_chipselect <= 1'b1;
                                    mem_write      <= 1'b1;
                                    state          <= S_WRITE;
                                end
                            endcase
                        end
                    end
                    S_WRITE: begin
                        // down-counter terminal count ends the load
                        cur_addr <= cur_addr + 1'b1;
                        remain   <= remain - 1'b1;
                        if (remain == CNT_W'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ACCEPT;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_loader.sv
// Directed bench for mem_byte_loader with a write scoreboard.
module tb_mem_byte_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [9:0]  start_addr;
    logic [10:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    mem_byte_loader #(.ADDR_W(10), .CNT_W(11)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .start_addr     (start_addr),
        .word_count     (word_count),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .checksum       (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    bit ready_seen = 1'b0;
    logic [41:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every memory strobe must match the next scoreboard entry
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_ready) ready_seen = 1'b1;
            if (done) done_cnt++;
            if (mem_write || mem_chipselect) begin
                logic [41:0] e;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(e[41:32]));
                    chk("wr_data", mem_writedata, e[31:0]);
                    chk("wr_strobes", {30'd0, mem_chipselect, mem_write}, 32'd3);
                    chk("wr_be", 32'(mem_byteenable), 32'hF);
                end
            end
        end
    end

    task automatic do_start(input logic [9:0] a, input logic [10:0] c);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        word_count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic run_load(input logic [9:0] a, input logic [10:0] c, input logic [7:0] seed,
                            input int max_gap, output logic [7:0] sum);
        logic [7:0]  bv;
        logic [31:0] word;
        logic [9:0]  wa;
        sum = 8'd0;
        do_start(a, c);
        for (int w = 0; w < int'(c); w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++) begin
                bv = seed + 8'(w * 4 + b);
                word[b*8 +: 8] = bv;
            end
            wa = a + 10'(w);
            exp_q.push_back({wa, word});
            for (int b = 0; b < 4; b++) begin
                sum = sum + word[b*8 +: 8];
                send_byte(word[b*8 +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            end
        end
        wait_idle("load_busy_end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sum;
        int d0, w0;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = 10'd0;
        word_count = 11'd0;
        in_data    = 8'd0;
        in_valid   = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_strobes", {30'd0, mem_chipselect, mem_write}, 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", mem_writedata, 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_be", 32'(mem_byteenable), 32'hF);
        chk("rst_clken", 32'(mem_clken), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // T1: two words from 0x010, bytes 01..08
        d0 = done_cnt; w0 = wr_cnt;
        run_load(10'h010, 11'd2, 8'h01, 0, sum);
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd2);
        chk("t1_checksum", 32'(checksum), 32'h24);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // T2: address wrap from 0x3FF to 0x000
        w0 = wr_cnt;
        run_load(10'h3FF, 11'd2, 8'hA0, 0, sum);
        chk("t2_writes", 32'(wr_cnt - w0), 32'd2);
        chk("t2_checksum", 32'(checksum), 32'(sum));

        // T3: zero-length load
        d0 = done_cnt; w0 = wr_cnt;
        ready_seen = 1'b0;
        do_start(10'h055, 11'd0);
        repeat (4) @(negedge clk);
        chk("t3_done", 32'(done_cnt - d0), 32'd1);
        chk("t3_writes", 32'(wr_cnt - w0), 32'd0);
        chk("t3_ready_seen", 32'(ready_seen), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);

        // T4: sixteen words with random stream gaps
        d0 = done_cnt; w0 = wr_cnt;
        run_load(10'h050, 11'd16, 8'h30, 3, sum);
        chk("t4_writes", 32'(wr_cnt - w0), 32'd16);
        chk("t4_done", 32'(done_cnt - d0), 32'd1);
        chk("t4_checksum", 32'(checksum), 32'(sum));
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // T5: abort after two bytes of the first word
        d0 = done_cnt; w0 = wr_cnt;
        do_start(10'h020, 11'd3);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        chk("t5_checksum", 32'(checksum), 32'h65);
        repeat (3) @(negedge clk);
        chk("t5_writes", 32'(wr_cnt - w0), 32'd0);
        chk("t5_done", 32'(done_cnt - d0), 32'd0);
        run_load(10'h020, 11'd1, 8'h11, 0, sum);
        chk("t5_restart_checksum", 32'(checksum), 32'(sum));
        chk("t5_restart_writes", 32'(wr_cnt - w0), 32'd1);

        // T6a: start while busy must not relatch address or count
        d0 = done_cnt; w0 = wr_cnt;
        do_start(10'h100, 11'd1);
        exp_q.push_back({10'h100, 32'hD4C3B2A1});
        @(negedge clk);
        start      = 1'b1;
        start_addr = 10'h200;
        word_count = 11'd5;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        wait_idle("t6_busy_end");
        chk("t6_writes", 32'(wr_cnt - w0), 32'd1);
        chk("t6_done", 32'(done_cnt - d0), 32'd1);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        // T6b: asynchronous reset in the middle of ACCEPT
        do_start(10'h300, 11'd4);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_checksum", 32'(checksum), 32'd0);
        chk("t6_rst_addr", 32'(mem_address), 32'd0);
        chk("t6_rst_wdata", mem_writedata, 32'd0);
        chk("t6_rst_strobes", {30'd0, mem_chipselect, mem_write}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        w0 = wr_cnt;
        run_load(10'h3FE, 11'd1, 8'h5C, 1, sum);
        chk("t6_post_writes", 32'(wr_cnt - w0), 32'd1);
        chk("t6_post_checksum", 32'(checksum), 32'(sum));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
